// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: issues word fetches, buffers up to two
// responses, and presents the instruction with opcode/func3/func7 slices to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned MAX_OUT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7
);

  localparam logic [2:0] CREDITS = 3'(MAX_OUT);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [1:0]  outstanding;
  logic [1:0]  drop_cnt;
  logic [1:0]  q_count;
  logic        q_rd_ptr;
  logic        q_wr_ptr;
  logic [31:0] q_mem [2];

  logic [2:0]  credits_used;
  logic        req_fire;
  logic        rsp_tracked;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        load;
  logic        q_pop;
  logic        bypass;
  logic        q_push;
  logic [31:0] redirect_aligned;
  logic        unused_redirect_lsb;

  assign redirect_aligned    = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Request handshake: a request transfers on a cycle where imem_req_valid and
  // imem_req_ready are both high; while valid is high and ready low the address holds.
  assign credits_used   = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = rst_n && !redirect_valid && (credits_used < CREDITS);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding belong to pre-reset requests and are ignored.
  assign rsp_tracked = imem_rsp_valid && (outstanding != 2'd0);
  assign rsp_drop    = rsp_tracked && ((drop_cnt != 2'd0) || redirect_valid);
  assign rsp_keep    = rsp_tracked && !rsp_drop;

  assign load   = !stall_d || !if_id_valid;
  assign q_pop  = !redirect_valid && load && (q_count != 2'd0);
  assign bypass = !redirect_valid && load && (q_count == 2'd0) && rsp_keep;
  assign q_push = rsp_keep && !bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_aligned;
    end else if (req_fire) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 2'd0;
    end else begin
      case ({req_fire, rsp_tracked})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // On redirect every request still in flight after this cycle must be discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 2'd0;
    end else if (redirect_valid) begin
      drop_cnt <= outstanding - {1'b0, rsp_tracked};
    end else if (rsp_tracked && (drop_cnt != 2'd0)) begin
      drop_cnt <= drop_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_count  <= 2'd0;
      q_rd_ptr <= 1'b0;
      q_wr_ptr <= 1'b0;
    end else if (redirect_valid) begin
      q_count  <= 2'd0;
      q_rd_ptr <= 1'b0;
      q_wr_ptr <= 1'b0;
    end else begin
      if (q_push) q_wr_ptr <= ~q_wr_ptr;
      if (q_pop)  q_rd_ptr <= ~q_rd_ptr;
      case ({q_push, q_pop})
        2'b10:   q_count <= q_count + 2'd1;
        2'b01:   q_count <= q_count - 2'd1;
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) q_mem[q_wr_ptr] <= imem_rsp_data;
  end

  // pc_d follows the in-order fetch stream, so it labels whatever IF/ID loads next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_d <= RESET_PC;
    end else if (redirect_valid) begin
      pc_d <= redirect_aligned;
    end else if (q_pop || bypass) begin
      pc_d <= pc_d + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (load) begin
      if (q_pop) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= pc_d;
        if_id_instr <= q_mem[q_rd_ptr];
      end else if (bypass) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= pc_d;
        if_id_instr <= imem_rsp_data;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

  assign if_id_pc4 = if_id_pc + 32'd4;
  assign opcode    = if_id_instr[6:0];
  assign func3     = if_id_instr[14:12];
  assign func7     = if_id_instr[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table for stream/stall/ready/redirect cases,
// plus hand sequences for PC wrap and asynchronous reset mid-stream.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;

  int checks   = 0;
  int failures = 0;
  logic mem_hold = 1'b0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_d(stall_d),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .opcode(opcode), .func3(func3), .func7(func7)
  );

  // ADDI x(n+1), x0, 5*(n+1) for word n: 0x00500093, 0x00A00113, ...
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] n;
    logic [11:0] imm;
    logic [4:0]  rd;
    n   = a >> 2;
    imm = 12'(5 * (n + 1));
    rd  = 5'(n + 1);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_if_id(input string tag, input logic ev, input logic [31:0] epc);
    logic [31:0] ei;
    ei = ev ? mem_word(epc) : NOP;
    check({tag, " if_id_valid"}, 32'(if_id_valid), 32'(ev));
    check({tag, " if_id_instr"}, if_id_instr, ei);
    check({tag, " opcode"}, 32'(opcode), 32'(ei[6:0]));
    check({tag, " func3"}, 32'(func3), 32'(ei[14:12]));
    check({tag, " func7"}, 32'(func7), 32'(ei[31:25]));
    if (ev) begin
      check({tag, " if_id_pc"}, if_id_pc, epc);
      check({tag, " if_id_pc4"}, if_id_pc4, epc + 32'd4);
    end
  endtask

  // Memory model: in-order, one-cycle latency, responses held back while mem_hold=1.
  initial begin
    logic [31:0] pend_q[$];
    logic        acc;
    logic [31:0] acc_addr;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      acc      = rst_n && imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pend_q.delete();
        imem_rsp_valid = 1'b0;
      end else begin
        if (acc) pend_q.push_back(acc_addr);
        if (!mem_hold && pend_q.size() > 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_q.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  ctl;   // {stall_d, imem_req_ready, mem_hold, redirect_valid}
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic        erv;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] rpc, input logic ev,
                              input logic [31:0] epc, input logic erv, input logic [31:0] eaddr);
    vec_t v;
    v.ctl = ctl; v.rpc = rpc; v.ev = ev; v.epc = epc; v.erv = erv; v.eaddr = eaddr;
    return v;
  endfunction

  vec_t vecs[32];

  initial begin
    int found;
    vecs[0]  = mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0);
    vecs[1]  = mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4);
    vecs[2]  = mk(4'b0100, 32'h0,   1'b1, 32'h0,   1'b1, 32'h8);
    vecs[3]  = mk(4'b0100, 32'h0,   1'b1, 32'h4,   1'b1, 32'hC);
    vecs[4]  = mk(4'b1100, 32'h0,   1'b1, 32'h8,   1'b1, 32'h10);
    vecs[5]  = mk(4'b1100, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0);
    vecs[6]  = mk(4'b1100, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0);
    vecs[7]  = mk(4'b1100, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0);
    vecs[8]  = mk(4'b0100, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0);
    vecs[9]  = mk(4'b0100, 32'h0,   1'b1, 32'hC,   1'b1, 32'h14);
    vecs[10] = mk(4'b0100, 32'h0,   1'b1, 32'h10,  1'b1, 32'h18);
    vecs[11] = mk(4'b0100, 32'h0,   1'b1, 32'h14,  1'b1, 32'h1C);
    vecs[12] = mk(4'b0100, 32'h0,   1'b1, 32'h18,  1'b1, 32'h20);
    vecs[13] = mk(4'b0000, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h24);
    vecs[14] = mk(4'b0000, 32'h0,   1'b1, 32'h20,  1'b1, 32'h24);
    vecs[15] = mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b1, 32'h24);
    vecs[16] = mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h24);
    vecs[17] = mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h28);
    vecs[18] = mk(4'b0100, 32'h0,   1'b1, 32'h24,  1'b1, 32'h2C);
    vecs[19] = mk(4'b0100, 32'h0,   1'b1, 32'h28,  1'b1, 32'h30);
    vecs[20] = mk(4'b0110, 32'h0,   1'b1, 32'h2C,  1'b1, 32'h34);
    vecs[21] = mk(4'b0111, 32'h104, 1'b0, 32'h0,   1'b0, 32'h0);
    vecs[22] = mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
    vecs[23] = mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h104);
    vecs[24] = mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h108);
    vecs[25] = mk(4'b0100, 32'h0,   1'b1, 32'h104, 1'b1, 32'h10C);
    vecs[26] = mk(4'b0100, 32'h0,   1'b1, 32'h108, 1'b1, 32'h110);
    vecs[27] = mk(4'b1101, 32'h203, 1'b1, 32'h10C, 1'b0, 32'h0);
    vecs[28] = mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200);
    vecs[29] = mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h204);
    vecs[30] = mk(4'b0100, 32'h0,   1'b1, 32'h200, 1'b1, 32'h208);
    vecs[31] = mk(4'b0100, 32'h0,   1'b1, 32'h204, 1'b1, 32'h20C);

    // Clock/reset: hold reset, check reset values, release with ready low.
    rst_n = 1'b0; imem_req_ready = 1'b0; stall_d = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset imem_req_valid", 32'(imem_req_valid), 32'd0);
    check("reset if_id_pc", if_id_pc, 32'd0);
    check_if_id("reset", 1'b0, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk);
      #1;
      {stall_d, imem_req_ready, mem_hold, redirect_valid} = v.ctl;
      redirect_pc = v.rpc;
      @(negedge clk);
      check($sformatf("c%0d imem_req_valid", i), 32'(imem_req_valid), 32'(v.erv));
      if (v.erv) check($sformatf("c%0d imem_req_addr", i), imem_req_addr, v.eaddr);
      check_if_id($sformatf("c%0d", i), v.ev, v.epc);
      check($sformatf("c%0d q_bound", i), 32'(dut.q_count <= 2'd2), 32'd1);
    end

    // PC wrap: redirect to the last word, then fetch must wrap to 0.
    @(posedge clk); #1;
    stall_d = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    check("wrap redirect req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1; redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap addr0", imem_req_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap addr1 valid", 32'(imem_req_valid), 32'd1);
    check("wrap addr1", imem_req_addr, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check_if_id("wrap ifid0", 1'b1, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    @(negedge clk);
    check_if_id("wrap ifid1", 1'b1, 32'h0);

    // Asynchronous reset in the middle of a clock phase.
    @(posedge clk); #3;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    check("async imem_req_valid", 32'(imem_req_valid), 32'd0);
    check("async if_id_pc", if_id_pc, 32'd0);
    check_if_id("async", 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    found = -1;
    for (int c = 0; c < 10 && found < 0; c++) begin
      @(posedge clk); #1;
      imem_req_ready = 1'b1;
      @(negedge clk);
      if (c == 0) begin
        check("post-reset req_valid", 32'(imem_req_valid), 32'd1);
        check("post-reset req_addr", imem_req_addr, 32'h0);
      end
      if (if_id_valid) found = c;
    end
    check("post-reset first valid cycle", 32'(found), 32'd2);
    check_if_id("post-reset", 1'b1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
